// File: rtl/load_aligner.sv
// Load-path aligner: one load request -> one or two aligned bus reads -> extracted, extended result.
// Latency: aligned zero-wait load responds 2 cycles after accept, a split load 3 cycles after accept.
// Backpressure: req_ready only in IDLE; bus_rd held until bus_ack; resp_valid/data held until resp_ready.
module load_aligner #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_se,
  output logic            bus_rd,
  output logic [XLEN-1:0] bus_addr,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);
  // Wide enough to hold ofs + n without overflow (max 2*BYTES-1).
  localparam int CNT_W = OFS_W + 2;

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  // Access size in bytes; size 11 is a 32-bit word, size 00 is the full XLEN.
  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    logic [CNT_W-1:0] n;
    case (size)
      2'b01:   n = CNT_W'(1);
      2'b10:   n = CNT_W'(2);
      2'b11:   n = CNT_W'(4);
      default: n = CNT_W'(BYTES);
    endcase
    return n;
  endfunction

  // Shift the addressed bytes down from the {hi,lo} pair, then sign- or zero-fill above the access width.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] pair,
                                              input logic [OFS_W-1:0]  ofs,
                                              input logic [1:0]        size,
                                              input logic              se);
    logic [XLEN-1:0]  raw;
    logic [XLEN-1:0]  mask;
    logic [CNT_W-1:0] n;
    logic             sign;
    raw  = XLEN'(pair >> {ofs, 3'b000});
    n    = size_bytes(size);
    mask = '1;
    sign = 1'b0;
    if (n == CNT_W'(1)) begin
      mask = XLEN'(8'hFF);
      sign = raw[7];
    end else if (n == CNT_W'(2)) begin
      mask = XLEN'(16'hFFFF);
      sign = raw[15];
    end else if (n < CNT_W'(BYTES)) begin
      // Only reachable for a 32-bit word inside a wider XLEN.
      mask = XLEN'(32'hFFFF_FFFF);
      sign = raw[31];
    end
    return (raw & mask) | ((se && sign) ? ~mask : '0);
  endfunction

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              bus_rd_q, bus_rd_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [1:0]        size_q, size_d;
  logic              se_q, se_d;
  logic              cross_q, cross_d;

  logic [OFS_W-1:0]  req_ofs;
  logic              req_cross;

  // Offset and word-crossing test for the incoming request.
  always_comb begin
    req_ofs   = req_addr[OFS_W-1:0];
    req_cross = (CNT_W'(req_ofs) + size_bytes(req_size)) > CNT_W'(BYTES);
  end

  // Next-state and next-output logic for the IDLE/RD0/RD1/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    bus_rd_d     = bus_rd_q;
    bus_addr_d   = bus_addr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    lo_d         = lo_q;
    ofs_d        = ofs_q;
    size_d       = size_q;
    se_d         = se_q;
    cross_d      = cross_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          ofs_d   = req_ofs;
          size_d  = req_size;
          se_d    = req_se;
          cross_d = req_cross;
          if (req_cross && !SPLIT_MISALIGNED) begin
            // Misaligned access with splitting disabled: report error, never touch the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d    = RD0;
            bus_rd_d   = 1'b1;
            bus_addr_d = req_addr & ~XLEN'(BYTES - 1);
          end
        end
      end
      RD0: begin
        if (bus_ack) begin
          lo_d = bus_rdata;
          if (cross_q) begin
            // Keep the strobe up and move to the next word; wraps naturally at the top of memory.
            state_d    = RD1;
            bus_addr_d = bus_addr_q + XLEN'(BYTES);
          end else begin
            state_d      = RESP;
            bus_rd_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = extract({{XLEN{1'b0}}, bus_rdata}, ofs_q, size_q, se_q);
          end
        end
      end
      RD1: begin
        if (bus_ack) begin
          state_d      = RESP;
          bus_rd_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = extract({bus_rdata, lo_q}, ofs_q, size_q, se_q);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset aborts any bus cycle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      bus_rd_q     <= 1'b0;
      bus_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      lo_q         <= '0;
      ofs_q        <= '0;
      size_q       <= '0;
      se_q         <= 1'b0;
      cross_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      bus_rd_q     <= bus_rd_d;
      bus_addr_q   <= bus_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      lo_q         <= lo_d;
      ofs_q        <= ofs_d;
      size_q       <= size_d;
      se_q         <= se_d;
      cross_q      <= cross_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign bus_rd     = bus_rd_q;
  assign bus_addr   = bus_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_aligner.sv
// Directed bench for load_aligner: one splitting instance and one error-flagging instance.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Bus acks and resp_ready driven by the bench; every wait is bounded.
module tb_load_aligner;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_se;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  logic        ns_req_valid;
  logic        ns_req_ready;
  logic        ns_bus_rd;
  logic [31:0] ns_bus_addr;
  logic        ns_bus_ack;
  logic        ns_resp_valid;
  logic        ns_resp_ready;
  logic [31:0] ns_resp_data;
  logic        ns_resp_err;

  int errors = 0;
  int checks = 0;

  load_aligner #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_se(req_se),
    .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  load_aligner #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_se(req_se),
    .bus_rd(ns_bus_rd), .bus_addr(ns_bus_addr), .bus_ack(ns_bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(ns_resp_valid), .resp_ready(ns_resp_ready), .resp_data(ns_resp_data),
    .resp_err(ns_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle.
  task automatic send_req(input logic [31:0] a, input logic [1:0] sz, input logic se);
    req_addr  = a;
    req_size  = sz;
    req_se    = se;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Single-cycle bus acknowledge with read data.
  task automatic ack(input logic [31:0] d);
    bus_rdata = d;
    bus_ack   = 1'b1;
    tick();
    bus_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL reset_bus_rd: got %b want 0", bus_rd); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    rst = 1'b0;
    tick();
  endtask

  // Aligned single-read loads: bus address and result checked at the zero-wait latency.
  task automatic test_single(input string name, input logic [31:0] a, input logic [1:0] sz,
                             input logic se, input logic [31:0] rd, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
    send_req(a, sz, se);
    checks++; if (bus_rd !== 1'b1) begin errors++; $display("FAIL %s bus_rd: got %b want 1", name, bus_rd); end
    checks++; if (bus_addr !== exp_addr) begin errors++; $display("FAIL %s bus_addr: got %h want %h", name, bus_addr, exp_addr); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s req_ready busy: got %b want 0", name, req_ready); end
    ack(rd);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s resp_valid: got %b want 1", name, resp_valid); end
    checks++; if (resp_data !== exp_data) begin errors++; $display("FAIL %s resp_data: got %h want %h", name, resp_data, exp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL %s resp_err: got %b want 0", name, resp_err); end
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL %s back_to_idle: valid=%b ready=%b want 0/1", name, resp_valid, req_ready); end
  endtask

  // Word-crossing loads: two reads at consecutive aligned addresses.
  task automatic test_split(input string name, input logic [31:0] a, input logic [1:0] sz,
                            input logic se, input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic [31:0] addr0, input logic [31:0] addr1,
                            input logic [31:0] exp_data);
    send_req(a, sz, se);
    checks++; if (bus_addr !== addr0 || bus_rd !== 1'b1) begin errors++; $display("FAIL %s first read: rd=%b addr=%h want 1/%h", name, bus_rd, bus_addr, addr0); end
    ack(rd0);
    checks++; if (bus_addr !== addr1 || bus_rd !== 1'b1) begin errors++; $display("FAIL %s second read: rd=%b addr=%h want 1/%h", name, bus_rd, bus_addr, addr1); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s early resp_valid: got %b want 0", name, resp_valid); end
    ack(rd1);
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_data) begin errors++; $display("FAIL %s result: valid=%b data=%h want 1/%h", name, resp_valid, resp_data, exp_data); end
    checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL %s bus_rd after: got %b want 0", name, bus_rd); end
    if (resp_ready) tick();
  endtask

  // Error-flagging instance: crossing half never reaches the bus; aligned word still works.
  task automatic test_misaligned_err();
    bit seen_rd = 0;
    bit got     = 0;
    ns_resp_ready = 1'b0;
    req_addr = 32'h0000_0003; req_size = 2'b10; req_se = 1'b1;
    ns_req_valid = 1'b1;
    tick();
    ns_req_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (ns_bus_rd) seen_rd = 1;
      if (ns_resp_valid) got = 1; else tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL err_timeout: resp_valid=%b want 1", ns_resp_valid); end
    checks++; if (seen_rd || ns_bus_rd !== 1'b0) begin errors++; $display("FAIL err_no_bus: bus_rd seen=%0d want 0", seen_rd); end
    checks++; if (ns_resp_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", ns_resp_err); end
    checks++; if (ns_resp_data !== 32'h0) begin errors++; $display("FAIL err_data: got %h want 0", ns_resp_data); end
    ns_resp_ready = 1'b1;
    tick();
    checks++; if (ns_resp_valid !== 1'b0 || ns_req_ready !== 1'b1) begin errors++; $display("FAIL err_release: valid=%b ready=%b want 0/1", ns_resp_valid, ns_req_ready); end
    req_addr = 32'h0000_0004; req_size = 2'b11; req_se = 1'b1;
    ns_req_valid = 1'b1;
    tick();
    ns_req_valid = 1'b0;
    checks++; if (ns_bus_rd !== 1'b1 || ns_bus_addr !== 32'h4) begin errors++; $display("FAIL ns_aligned_read: rd=%b addr=%h want 1/00000004", ns_bus_rd, ns_bus_addr); end
    bus_rdata = 32'hCAFE_F00D;
    ns_bus_ack = 1'b1;
    tick();
    ns_bus_ack = 1'b0;
    checks++; if (ns_resp_valid !== 1'b1 || ns_resp_data !== 32'hCAFE_F00D || ns_resp_err !== 1'b0) begin errors++; $display("FAIL ns_aligned_result: valid=%b data=%h err=%b want 1/cafef00d/0", ns_resp_valid, ns_resp_data, ns_resp_err); end
    tick();
  endtask

  // Top-of-memory wrap with consumer backpressure: result held, new requests ignored.
  task automatic test_wrap_hold();
    resp_ready = 1'b0;
    test_split("wrap", 32'hFFFF_FFFE, 2'b11, 1'b0, 32'h1122_3344, 32'h5566_7788,
               32'hFFFF_FFFC, 32'h0000_0000, 32'h7788_1122);
    req_addr = 32'h0000_0200; req_size = 2'b11; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h7788_1122) begin errors++; $display("FAIL hold_%0d: valid=%b data=%h want 1/77881122", i, resp_valid, resp_data); end
      checks++; if (req_ready !== 1'b0 || bus_rd !== 1'b0) begin errors++; $display("FAIL hold_ignore_%0d: ready=%b rd=%b want 0/0", i, req_ready, bus_rd); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hold_release: valid=%b ready=%b want 0/1", resp_valid, req_ready); end
  endtask

  // Reset during the second read: strobe drops without a clock edge, later ack ignored.
  task automatic test_reset_mid();
    send_req(32'h0000_0102, 2'b11, 1'b0);
    ack(32'hAABB_CCDD);
    checks++; if (bus_rd !== 1'b1 || bus_addr !== 32'h104) begin errors++; $display("FAIL midrst_in_rd1: rd=%b addr=%h want 1/00000104", bus_rd, bus_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL midrst_async_rd: got %b want 0", bus_rd); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    #2 rst = 1'b0;
    tick();
    ack(32'h1122_3344);
    checks++; if (resp_valid !== 1'b0 || bus_rd !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ack_ignored: valid=%b rd=%b ready=%b want 0/0/1", resp_valid, bus_rd, req_ready); end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_se = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0; resp_ready = 1'b1;
    ns_req_valid = 1'b0; ns_bus_ack = 1'b0; ns_resp_ready = 1'b1;
    test_reset();
    test_single("byte_se",   32'h0000_0103, 2'b01, 1'b1, 32'h80FF_1234, 32'h100, 32'hFFFF_FF80);
    test_single("byte_ze",   32'h0000_0103, 2'b01, 1'b0, 32'h80FF_1234, 32'h100, 32'h0000_0080);
    test_single("half_se",   32'h0000_0102, 2'b10, 1'b1, 32'h8001_0000, 32'h100, 32'hFFFF_8001);
    test_single("half_ze1",  32'h0000_0101, 2'b10, 1'b0, 32'h12AB_CD34, 32'h100, 32'h0000_ABCD);
    test_single("word_full", 32'h0000_0100, 2'b00, 1'b1, 32'h8000_0001, 32'h100, 32'h8000_0001);
    test_split("split_word", 32'h0000_0102, 2'b11, 1'b1, 32'hAABB_CCDD, 32'h1122_3344,
               32'h100, 32'h104, 32'h3344_AABB);
    test_split("split_half", 32'h0000_0103, 2'b10, 1'b1, 32'hAA00_0000, 32'h0000_00BB,
               32'h100, 32'h104, 32'hFFFF_BBAA);
    test_misaligned_err();
    test_wrap_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
